spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
- Serial transfer engine directly downstream of the SPI APB slave interface.
- Consumes the control fields (mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode, spiswai) and the send_data/tx byte hand-off from that interface.
- Generates SCLK at the programmed baud rate, drives SS and MOSI, and shifts in MISO.
- Returns the received byte with a receive_data strobe and reports tip (transfer in progress) back upstream.

Parameters:
- DATA_W, 8, transfer length in bits (fixed 8 for this design; edge counter sized from it)
- DIV_W, 12, width of baud_divisor output

Ports:
- PCLK  in  1  system clock
- PRESETn  in  1  async active-low reset
- mstr  in  1  master enable; 0 = engine held idle, aborts any transfer
- cpol  in  1  SCLK idle level
- cpha  in  1  clock phase; 0 = sample leading edge, 1 = sample trailing edge
- lsbfe  in  1  1 = LSB first, 0 = MSB first
- sppr  in  3  baud prescaler select
- spr  in  3  baud rate select
- spi_mode  in  2  00 run, 01 wait, 10 stop
- spiswai  in  1  stop SPI clock while in wait mode
- send_data  in  1  one-cycle start request
- tx_data  in  8  byte to transmit, sampled with send_data
- miso  in  1  serial input
- sclk  out  1  serial clock
- ss  out  1  slave select, active low
- mosi  out  1  serial output
- tip  out  1  transfer in progress
- receive_data  out  1  one-cycle strobe, rx_data valid
- rx_data  out  8  last received byte
- baud_divisor  out  12  (sppr+1)*2^(spr+1), combinational from live inputs

Behaviour:
- All PRESETn values:
  - sclk=0, ss=1, mosi=0, tip=0, receive_data=0, rx_data=8'h00.
  - State IDLE.
  - Counters cleared.
- Reset mid-transfer takes effect immediately (async): no strobe; outputs take their reset values.
- Half period: half = (sppr+1)<<spr PCLK cycles, range 1..1024.
  - A 11-bit counter counts 0..half-1.
  - An "edge event" fires on the cycle the counter equals half-1; the counter then wraps to 0.
- Clock gating (the freeze condition): the counter and state advance only when spi_mode==00, or spi_mode==01 with spiswai==0.
  - Otherwise all state and outputs hold, including mid-transfer.
  - Operation resumes exactly where it froze.
- Start:
  - send_data is accepted only when all of the following hold: state IDLE, mstr=1, spi_mode!=10.
  - In any other case it is ignored, including while busy; there is no queuing.
- Latching on accept cycle T:
  - tx_data is loaded into the shift register.
  - cpol, cpha, lsbfe, sppr and spr are latched and used for the whole transfer.
- At T+1:
  - ss=0, tip=1.
  - sclk stays at cpol.
  - mosi = first bit (tx[7] if lsbfe=0, tx[0] if lsbfe=1).
  - Counter cleared.
- State machine IDLE -> LEAD -> XFER -> TRAIL -> IDLE:
  - LEAD: waits one edge event (half cycles), then goes to XFER.
  - XFER:
    - Each edge event toggles sclk and increments the edge count 1..16.
    - Odd edges are leading, even edges trailing.
  - CPHA=0 timing:
    - Sample miso on odd edges.
    - Drive the next bit on even edges 2..14.
  - CPHA=1 timing:
    - Drive the next bit on odd edges 3..15.
    - Sample miso on even edges.
    - The first bit stays driven from ss fall.
  - After edge 16, sclk is back at cpol and the FSM goes to TRAIL.
  - TRAIL: waits one edge event. Then, on that cycle:
    - ss=1, tip=0.
    - rx_data updated.
    - receive_data=1 for exactly one cycle.
    - State returns to IDLE.
- Shift direction follows lsbfe for both TX and RX; the received bit enters the opposite end from the transmitted bit.
- SS timing: ss is low for exactly 18*half PCLK cycles when unfrozen.
- Earliest next start: send_data on the cycle after the receive_data strobe.
- Abort: if mstr drops while not IDLE, then on the next PCLK:
  - ss=1, tip=0, sclk=latched cpol, state IDLE.
  - No receive_data strobe; rx_data is unchanged.
- mosi holds its last bit after the transfer; it is not tristated.

Test Plan:
- Reset, then sppr=0, spr=0, cpol=0, cpha=0, lsbfe=0, tx=0xA5, slave model returns 0x3C -> half=1, baud_divisor=2, ss low 18 cycles, 8 sclk rising edges, mosi bit sequence 1,0,1,0,0,1,0,1, rx_data=0x3C, one receive_data pulse, tip low with ss high.
- sppr=2, spr=1 -> baud_divisor=12, half=6; cpol=1, cpha=1, lsbfe=1, tx=0x81 -> sclk idles high, first falling edge 6 cycles after ss fall, mosi LSB first, loopback miso=mosi gives rx_data=0x81.
- send_data pulsed mid-transfer, with mstr=0, and with spi_mode=10 -> ignored: no ss change, no extra strobe.
- spi_mode=01 with spiswai=1 asserted for 20 cycles mid-transfer -> sclk, ss and the counter frozen; on release the transfer completes with the correct rx byte; ss low time = 18*half+20.
- mstr cleared after edge 5 -> next cycle ss=1, tip=0, sclk=cpol, no receive_data, rx_data unchanged; a new send is accepted next cycle.
- PRESETn asserted mid-transfer -> all outputs at reset values asynchronously; after release a transfer of 0x5A completes normally.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI master serial engine: baud generation, SS/SCLK/MOSI drive and MISO capture.
// Transfer settings are latched at start and held for the whole byte.
module spi_master_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 12
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              mstr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [2:0]        sppr,
    input  logic [2:0]        spr,
    input  logic [1:0]        spi_mode,
    input  logic              spiswai,
    input  logic              send_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    output logic              tip,
    output logic              receive_data,
    output logic [DATA_W-1:0] rx_data,
    output logic [DIV_W-1:0]  baud_divisor
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    logic [1:0]        state_q, state_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsbfe_q, lsbfe_d;
    logic [2:0]        sppr_q, sppr_d;
    logic [2:0]        spr_q, spr_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              tip_q, tip_d;
    logic              rcv_q, rcv_d;

    logic [10:0]   half;
    logic [10:0]   half_m1;
    logic          run;
    logic          accept;
    logic          edge_ev;
    logic [EW-1:0] e_nx;
    logic          smp;
    logic          drv;

    assign baud_divisor = ({{(DIV_W-3){1'b0}}, sppr} + DIV_W'(1))
                          << ({1'b0, spr} + 4'd1);

    assign half    = ({8'd0, sppr_q} + 11'd1) << spr_q;
    assign half_m1 = half - 11'd1;

    // Freeze: in wait mode with spiswai set, or in stop mode, nothing advances.
    assign run = (spi_mode == 2'b00) || (spi_mode == 2'b01 && !spiswai);
    assign accept = (state_q == S_IDLE) && mstr && (spi_mode != 2'b10)
                    && run && send_data;
    assign edge_ev = run && (cnt_q == half_m1);
    assign e_nx = edge_q + EW'(1);

    // Odd edges lead, even edges trail; CPHA picks which one samples.
    assign smp = cpha_q ? !e_nx[0] : e_nx[0];
    assign drv = cpha_q ? (e_nx[0] && e_nx != EW'(1))
                        : (!e_nx[0] && e_nx != LAST_EDGE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsbfe_d   = lsbfe_q;
        sppr_d    = sppr_q;
        spr_d     = spr_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        tip_d     = tip_q;
        rcv_d     = 1'b0;
        if (state_q != S_IDLE && !mstr) begin
            state_d = S_IDLE;
            ss_d    = 1'b1;
            tip_d   = 1'b0;
            sclk_d  = cpol_q;
            cnt_d   = '0;
            edge_d  = '0;
        end else if (accept) begin
            state_d = S_LEAD;
            tx_sr_d = tx_data;
            rx_sr_d = '0;
            cpol_d  = cpol;
            cpha_d  = cpha;
            lsbfe_d = lsbfe;
            sppr_d  = sppr;
            spr_d   = spr;
            ss_d    = 1'b0;
            tip_d   = 1'b1;
            sclk_d  = cpol;
            mosi_d  = lsbfe ? tx_data[0] : tx_data[DATA_W-1];
            cnt_d   = '0;
            edge_d  = '0;
        end else if (run && state_q != S_IDLE) begin
            cnt_d = edge_ev ? 11'd0 : cnt_q + 11'd1;
            if (edge_ev) begin
                unique case (state_q)
                    S_LEAD: state_d = S_XFER;
                    S_XFER: begin
                        edge_d = e_nx;
                        sclk_d = !sclk_q;
                        if (smp) begin
                            rx_sr_d = lsbfe_q ? {miso, rx_sr_q[DATA_W-1:1]}
                                              : {rx_sr_q[DATA_W-2:0], miso};
                        end
                        if (drv) begin
                            tx_sr_d = lsbfe_q ? tx_sr_q >> 1 : tx_sr_q << 1;
                            mosi_d  = lsbfe_q ? tx_sr_q[1] : tx_sr_q[DATA_W-2];
                        end
                        if (e_nx == LAST_EDGE) state_d = S_TRAIL;
                    end
                    S_TRAIL: begin
                        state_d   = S_IDLE;
                        ss_d      = 1'b1;
                        tip_d     = 1'b0;
                        rx_data_d = rx_sr_q;
                        rcv_d     = 1'b1;
                        edge_d    = '0;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            sppr_q    <= '0;
            spr_q     <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            tip_q     <= 1'b0;
            rcv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsbfe_q   <= lsbfe_d;
            sppr_q    <= sppr_d;
            spr_q     <= spr_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            tip_q     <= tip_d;
            rcv_q     <= rcv_d;
        end
    end

    assign sclk         = sclk_q;
    assign ss           = ss_q;
    assign mosi         = mosi_q;
    assign tip          = tip_q;
    assign receive_data = rcv_q;
    assign rx_data      = rx_data_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine with a cycle-sampled SPI slave model.
// Table vectors cover modes; sequences cover ignore, freeze, abort, reset.
module tb_spi_master_engine;

    logic       PCLK = 0;
    logic       PRESETn = 1;
    logic       mstr = 0, cpol = 0, cpha = 0, lsbfe = 0;
    logic [2:0] sppr = 0, spr = 0;
    logic [1:0] spi_mode = 0;
    logic       spiswai = 0, send_data = 0;
    logic [7:0] tx_data = 0;
    logic       miso;
    logic       sclk, ss, mosi, tip, receive_data;
    logic [7:0] rx_data;
    logic [11:0] baud_divisor;

    spi_master_engine dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .mstr(mstr), .cpol(cpol),
        .cpha(cpha), .lsbfe(lsbfe), .sppr(sppr), .spr(spr),
        .spi_mode(spi_mode), .spiswai(spiswai), .send_data(send_data),
        .tx_data(tx_data), .miso(miso), .sclk(sclk), .ss(ss),
        .mosi(mosi), .tip(tip), .receive_data(receive_data),
        .rx_data(rx_data), .baud_divisor(baud_divisor)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // slave model / monitor state
    int ss_low, n_edge, n_rise, n_strobe, sidx, midx;
    logic [7:0] mbits, sl_byte;
    logic sl_miso = 0, loop = 0, ss_p = 1, sclk_p = 0, first_lvl = 0;

    assign miso = loop ? mosi : sl_miso;

    function automatic logic sl_bit(input int i);
        return lsbfe ? sl_byte[i] : sl_byte[7-i];
    endfunction

    function automatic logic [7:0] mbyte();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[lsbfe ? i : 7-i] = mbits[i];
        return r;
    endfunction

    always @(negedge PCLK) begin
        if (!ss) ss_low++;
        if (receive_data) n_strobe++;
        if (ss_p && !ss) begin
            sidx = 0; midx = 0; n_edge = 0;
            sl_miso = sl_bit(0);
        end else if (!ss && sclk != sclk_p) begin
            n_edge++;
            if (n_edge == 1) first_lvl = sclk;
            if (sclk && !sclk_p) n_rise++;
            if ((!cpha && n_edge[0]) || (cpha && !n_edge[0])) begin
                if (midx < 8) mbits[midx] = mosi;
                midx++;
            end
            if ((!cpha && !n_edge[0] && n_edge < 16) ||
                (cpha && n_edge[0] && n_edge > 1)) begin
                sidx++;
                if (sidx < 8) sl_miso = sl_bit(sidx);
            end
        end
        ss_p = ss;
        sclk_p = sclk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        ss_low = 0; n_edge = 0; n_rise = 0; n_strobe = 0;
        mbits = 0;
    endtask

    typedef struct {
        logic       cpol, cpha, lsbfe;
        logic [2:0] sppr, spr;
        logic [7:0] tx, sb;
        logic       lp;
        int         div, half;
        logic [7:0] rx;
    } vec_t;

    vec_t tv[4];

    task automatic set_cfg(input vec_t v);
        @(negedge PCLK);
        cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe;
        sppr = v.sppr; spr = v.spr; loop = v.lp; sl_byte = v.sb;
        #1 chk("baud_div", baud_divisor, v.div);
    endtask

    task automatic do_send(input logic [7:0] d);
        @(negedge PCLK);
        tx_data = d; send_data = 1;
        @(negedge PCLK);
        send_data = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n_strobe == 0 && n < 3000) begin
            @(negedge PCLK); n++;
        end
        chk("done_timeout", n_strobe != 0, 1);
        repeat (2) @(negedge PCLK);
    endtask

    task automatic wait_edges(input int k);
        int n = 0;
        while (n_edge < k && n < 3000) begin
            @(negedge PCLK); n++;
        end
        chk("edge_timeout", n_edge >= k, 1);
    endtask

    vec_t fz;
    logic [7:0] last_rx;
    int e0;

    initial begin
        tv[0] = '{0, 0, 0, 3'd0, 3'd0, 8'hA5, 8'h3C, 0, 2, 1, 8'h3C};
        tv[1] = '{1, 1, 1, 3'd2, 3'd1, 8'h81, 8'h00, 1, 12, 6, 8'h81};
        tv[2] = '{0, 1, 0, 3'd1, 3'd0, 8'hC3, 8'h5A, 0, 4, 2, 8'h5A};
        tv[3] = '{1, 0, 1, 3'd0, 3'd2, 8'h3C, 8'h96, 0, 8, 4, 8'h96};
        fz    = '{0, 1, 0, 3'd1, 3'd0, 8'hE7, 8'h42, 0, 4, 2, 8'h42};
        clear_mon();

        #1 PRESETn = 0;
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_ss", ss, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_tip", tip, 0);
        chk("rst_rcv", receive_data, 0);
        chk("rst_rx", rx_data, 0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1;
        mstr = 1;

        for (int i = 0; i < 4; i++) begin
            set_cfg(tv[i]);
            clear_mon();
            do_send(tv[i].tx);
            wait_done();
            chk("rx_data", rx_data, tv[i].rx);
            chk("ss_low", ss_low, 18 * tv[i].half);
            chk("mosi_byte", mbyte(), tv[i].tx);
            chk("strobes", n_strobe, 1);
            chk("sclk_edges", n_edge, 16);
            chk("sclk_rises", n_rise, 8);
            chk("first_edge", first_lvl, !tv[i].cpol);
            chk("end_tip", tip, 0);
            chk("end_ss", ss, 1);
            chk("end_sclk", sclk, tv[i].cpol);
        end
        loop = 0;

        // send during transfer is dropped
        set_cfg(fz);
        sl_byte = 8'hC3;
        clear_mon();
        do_send(8'h3C);
        wait_edges(3);
        do_send(8'hFF);
        wait_done();
        chk("ign_busy_strobes", n_strobe, 1);
        chk("ign_busy_sslow", ss_low, 36);
        chk("ign_busy_rx", rx_data, 8'hC3);
        chk("ign_busy_mosi", mbyte(), 8'h3C);

        mstr = 0;
        clear_mon();
        do_send(8'h55);
        repeat (10) @(negedge PCLK);
        chk("ign_mstr_ss", ss_low, 0);
        chk("ign_mstr_rcv", n_strobe, 0);
        mstr = 1;

        spi_mode = 2'b10;
        clear_mon();
        do_send(8'h55);
        repeat (10) @(negedge PCLK);
        chk("ign_stop_ss", ss_low, 0);
        chk("ign_stop_rcv", n_strobe, 0);
        spi_mode = 2'b00;

        // wait-mode freeze for 20 cycles
        set_cfg(fz);
        clear_mon();
        do_send(fz.tx);
        wait_edges(6);
        spi_mode = 2'b01; spiswai = 1;
        e0 = n_edge;
        repeat (20) @(negedge PCLK);
        chk("frz_edges", n_edge, e0);
        chk("frz_ss", ss, 0);
        spi_mode = 2'b00; spiswai = 0;
        wait_done();
        chk("frz_sslow", ss_low, 36 + 20);
        chk("frz_rx", rx_data, 8'h42);
        chk("frz_mosi", mbyte(), 8'hE7);
        last_rx = 8'h42;

        // abort by dropping mstr
        sl_byte = 8'h99;
        clear_mon();
        do_send(8'h11);
        wait_edges(5);
        mstr = 0;
        @(negedge PCLK);
        chk("abt_ss", ss, 1);
        chk("abt_tip", tip, 0);
        chk("abt_sclk", sclk, fz.cpol);
        chk("abt_rcv", n_strobe, 0);
        chk("abt_rx", rx_data, last_rx);
        mstr = 1;
        sl_byte = 8'hDB;
        tx_data = 8'h24; send_data = 1;
        @(negedge PCLK);
        send_data = 0;
        chk("abt_restart_ss", ss, 0);
        wait_done();
        chk("abt_restart_rx", rx_data, 8'hDB);
        chk("abt_restart_mosi", mbyte(), 8'h24);

        // asynchronous reset mid-transfer
        sl_byte = 8'h66;
        clear_mon();
        do_send(8'h77);
        wait_edges(4);
        #2 PRESETn = 0;
        #1;
        chk("mrst_sclk", sclk, 0);
        chk("mrst_ss", ss, 1);
        chk("mrst_mosi", mosi, 0);
        chk("mrst_tip", tip, 0);
        chk("mrst_rcv", receive_data, 0);
        chk("mrst_rx", rx_data, 0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        sl_byte = 8'hA5;
        clear_mon();
        do_send(8'h5A);
        wait_done();
        chk("post_rst_rx", rx_data, 8'hA5);
        chk("post_rst_mosi", mbyte(), 8'h5A);
        chk("post_rst_sslow", ss_low, 36);
        chk("post_rst_strobes", n_strobe, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
